// File: rtl/alu_seq_pkg.sv
// Shared opcodes, header size and FSM state encoding for the ALU packet sequencer.
// ALU_SEQ_ECHO_EN adds the ECHO state to the encoding.
package alu_seq_pkg;

    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_MUL    = 8'h02;
    localparam logic [7:0] OP_ECHO   = 8'hEC;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [3:0] {
        HDR_OP,
        HDR_RSV,
        HDR_LEN_LO,
        HDR_LEN_HI,
        OPERAND,
        MUL_REQ,
        MUL_WAIT,
        RESULT,
        DRAIN
`ifdef ALU_SEQ_ECHO_EN
        , ECHO
`endif
    } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_result_ser.sv
// NB-byte LSB-first result serializer with a valid/ready byte output.
module alu_seq_result_ser #(
    parameter int NB = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [NB*8-1:0] data_i,
    output logic [7:0]      tdata_o,
    output logic            tvalid_o,
    input  logic            tready_i,
    output logic            last_o
);

    localparam int CW = $clog2(NB + 1);

    logic [NB*8-1:0] shreg_q;
    logic [CW-1:0]   cnt_q;

    assign tvalid_o = (cnt_q != '0);
    assign tdata_o  = shreg_q[7:0];
    assign last_o   = tvalid_o && tready_i && (cnt_q == CW'(1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= CW'(NB);
        end else if (tvalid_o && tready_i) begin
            shreg_q <= shreg_q >> 8;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_packet_sequencer.sv
// Packet-level controller between UART RX/TX and the ALU datapath (ADD, MUL, ECHO).
// ALU_SEQ_ECHO_EN enables ECHO pass-through; without it opcode 0xEC is drained.
//
// state      | meaning
// HDR_OP     | wait for opcode byte
// HDR_RSV    | skip reserved byte
// HDR_LEN_LO | capture length LSB
// HDR_LEN_HI | capture length MSB, dispatch on opcode
// OPERAND    | assemble NB-byte operand, LSB first
// MUL_REQ    | present acc/operand to multiplier until accepted
// MUL_WAIT   | wait for product pulse
// RESULT     | serialize acc to TX
// ECHO       | RX->TX pass-through for the payload
// DRAIN      | consume payload of unknown opcode
module alu_packet_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [7:0]               rx_tdata_i,
    input  logic                     rx_tvalid_i,
    output logic                     rx_tready_o,
    output logic [7:0]               tx_tdata_o,
    output logic                     tx_tvalid_o,
    input  logic                     tx_tready_i,
    output logic                     mul_valid_o,
    output logic [OPERAND_WIDTH-1:0] mul_a_o,
    output logic [OPERAND_WIDTH-1:0] mul_b_o,
    input  logic                     mul_ready_i,
    input  logic                     mul_done_i,
    input  logic [OPERAND_WIDTH-1:0] mul_result_i
);

    localparam int NB  = OPERAND_WIDTH / 8;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

    alu_seq_state_e           state_q, state_d;
    logic [7:0]               opcode_q, opcode_d;
    logic [7:0]               len_lo_q, len_lo_d;
    logic [15:0]              rem_q, rem_d;
    logic [BIW-1:0]           idx_q, idx_d;
    logic [OPERAND_WIDTH-1:0] operand_q, operand_d;
    logic [OPERAND_WIDTH-1:0] acc_q, acc_d;
    logic                     have_op_q, have_op_d;

    logic                     rdy;
    logic                     rx_hs;
    logic                     mul_valid;
    logic                     echo_active;
    logic [OPERAND_WIDTH-1:0] op_full;
    logic [15:0]              len_full;
    logic [15:0]              plen;
    logic                     ser_load;
    logic [7:0]               ser_tdata;
    logic                     ser_tvalid;
    logic                     ser_last;

    always_comb begin
        op_full = operand_q;
        op_full[8*int'(idx_q) +: 8] = rx_tdata_i;
    end

    assign len_full = {rx_tdata_i, len_lo_q};
    assign plen     = (len_full < 16'(HDR_BYTES)) ? 16'd0 : len_full - 16'(HDR_BYTES);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        operand_d   = operand_q;
        acc_d       = acc_q;
        have_op_d   = have_op_q;
        rdy         = 1'b0;
        rx_hs       = 1'b0;
        mul_valid   = 1'b0;
        echo_active = 1'b0;

        case (state_q)
            HDR_OP: begin
                rdy = 1'b1;
                rx_hs = rx_tvalid_i;
                if (rx_hs) begin
                    opcode_d = rx_tdata_i;
                    state_d  = HDR_RSV;
                end
            end
            HDR_RSV: begin
                rdy = 1'b1;
                rx_hs = rx_tvalid_i;
                if (rx_hs) state_d = HDR_LEN_LO;
            end
            HDR_LEN_LO: begin
                rdy = 1'b1;
                rx_hs = rx_tvalid_i;
                if (rx_hs) begin
                    len_lo_d = rx_tdata_i;
                    state_d  = HDR_LEN_HI;
                end
            end
            HDR_LEN_HI: begin
                rdy = 1'b1;
                rx_hs = rx_tvalid_i;
                if (rx_hs) begin
                    rem_d     = plen;
                    idx_d     = '0;
                    have_op_d = 1'b0;
                    // Seeding acc with the identity gives the zero-operand result for free
                    acc_d     = (opcode_q == OP_MUL) ? OPERAND_WIDTH'(1) : '0;
                    if (opcode_q == OP_ADD || opcode_q == OP_MUL)
                        state_d = (plen == 16'd0) ? RESULT : OPERAND;
`ifdef ALU_SEQ_ECHO_EN
                    else if (opcode_q == OP_ECHO)
                        state_d = (plen == 16'd0) ? HDR_OP : ECHO;
`endif
                    else
                        state_d = (plen == 16'd0) ? HDR_OP : DRAIN;
                end
            end
            OPERAND: begin
                rdy = 1'b1;
                rx_hs = rx_tvalid_i;
                if (rx_hs && rem_q != 16'd0) begin
                    rem_d     = rem_q - 16'd1;
                    operand_d = op_full;
                    if (idx_q == BIW'(NB - 1)) begin
                        idx_d = '0;
                        if (!have_op_q || opcode_q == OP_ADD) begin
                            acc_d     = have_op_q ? acc_q + op_full : op_full;
                            have_op_d = 1'b1;
                            if (rem_q == 16'd1) state_d = RESULT;
                        end else begin
                            state_d = MUL_REQ;
                        end
                    end else begin
                        idx_d = idx_q + BIW'(1);
                        if (rem_q == 16'd1) state_d = RESULT;
                    end
                end
            end
            MUL_REQ: begin
                mul_valid = 1'b1;
                if (mul_ready_i) state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_done_i) begin
                    acc_d   = mul_result_i;
                    state_d = (rem_q == 16'd0) ? RESULT : OPERAND;
                end
            end
            RESULT: begin
                if (ser_last) state_d = HDR_OP;
            end
`ifdef ALU_SEQ_ECHO_EN
            ECHO: begin
                echo_active = 1'b1;
                rdy = tx_tready_i;
                rx_hs = rx_tvalid_i && tx_tready_i;
                if (rx_hs && rem_q != 16'd0) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = HDR_OP;
                end
            end
`endif
            DRAIN: begin
                rdy = 1'b1;
                rx_hs = rx_tvalid_i;
                if (rx_hs && rem_q != 16'd0) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = HDR_OP;
                end
            end
            default: state_d = HDR_OP;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= HDR_OP;
            opcode_q  <= '0;
            len_lo_q  <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            have_op_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            len_lo_q  <= len_lo_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            have_op_q <= have_op_d;
        end
    end

    // Load with the next-cycle acc so the final ADD/MUL update is included
    assign ser_load = (state_d == RESULT) && (state_q != RESULT);

    alu_seq_result_ser #(.NB(NB)) u_ser (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (ser_load),
        .data_i   (acc_d),
        .tdata_o  (ser_tdata),
        .tvalid_o (ser_tvalid),
        .tready_i (tx_tready_i),
        .last_o   (ser_last)
    );

    // HDR_OP is the reset state, so ready must be masked while reset is held
    assign rx_tready_o = rdy && !reset_i;
    assign mul_valid_o = mul_valid;
    assign mul_a_o     = mul_valid ? acc_q : '0;
    assign mul_b_o     = mul_valid ? operand_q : '0;

`ifdef ALU_SEQ_ECHO_EN
    assign tx_tdata_o  = echo_active ? rx_tdata_i : ser_tdata;
    assign tx_tvalid_o = echo_active ? rx_tvalid_i : ser_tvalid;
`else
    assign tx_tdata_o  = ser_tdata;
    assign tx_tvalid_o = ser_tvalid;
`endif

endmodule

// File: tb/tb_alu_packet_sequencer.sv
// Scoreboard bench for alu_packet_sequencer: directed packets, 3-cycle multiplier model.
module tb_alu_packet_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic        mul_valid;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic        mul_done;
    logic [31:0] mul_result;

    logic [7:0]  exp_q[$];
    logic [31:0] mul_exp_a[$];
    logic [31:0] mul_exp_b[$];
    int          total = 0;
    int          bad = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    always #5 clk = ~clk;

    alu_packet_sequencer #(.OPERAND_WIDTH(32)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .rx_tdata_i   (rx_tdata),
        .rx_tvalid_i  (rx_tvalid),
        .rx_tready_o  (rx_tready),
        .tx_tdata_o   (tx_tdata),
        .tx_tvalid_o  (tx_tvalid),
        .tx_tready_i  (tx_tready),
        .mul_valid_o  (mul_valid),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_ready_i  (mul_ready),
        .mul_done_i   (mul_done),
        .mul_result_i (mul_result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // TX monitor: pops the scoreboard on every handshake, checks hold under backpressure
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev) begin
                check("tx_hold_valid", {31'd0, tx_tvalid}, 32'd1);
                check("tx_hold_data", {24'd0, tx_tdata}, {24'd0, stall_data});
            end
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_tdata);
                end else begin
                    check("tx_byte", {24'd0, tx_tdata}, {24'd0, exp_q.pop_front()});
                end
            end
            stall_prev = tx_tvalid && !tx_tready;
            stall_data = tx_tdata;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Multiplier model: accepts one cycle after request, product pulse 3 cycles after accept
    initial begin
        logic [31:0] ea, eb;
        mul_ready  = 1'b0;
        mul_done   = 1'b0;
        mul_result = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset && mul_valid) begin
                if (mul_exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mul_unexpected: got a=%h b=%h expected no request", mul_a, mul_b);
                    ea = 32'd0;
                    eb = 32'd0;
                end else begin
                    ea = mul_exp_a.pop_front();
                    eb = mul_exp_b.pop_front();
                    check("mul_a", mul_a, ea);
                    check("mul_b", mul_b, eb);
                end
                @(posedge clk); #1 mul_ready = 1'b1;
                @(posedge clk); #1 mul_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 mul_done = 1'b1;
                mul_result = ea * eb;
                @(posedge clk); #1 mul_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rx_tready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            total++;
            bad++;
            $display("FAIL rx_timeout: got no ready expected accept of %h", b);
        end
        @(posedge clk); #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
        send_byte(op);
        send_byte(8'h00);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_mul(input logic [31:0] a, input logic [31:0] b);
        mul_exp_a.push_back(a);
        mul_exp_b.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mul_exp_a.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_idle_ready"}, {31'd0, rx_tready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_tready"}, {31'd0, rx_tready}, 32'd0);
        check({name, "_tx_tvalid"}, {31'd0, tx_tvalid}, 32'd0);
        check({name, "_tx_tdata"}, {24'd0, tx_tdata}, 32'd0);
        check({name, "_mul_valid"}, {31'd0, mul_valid}, 32'd0);
        check({name, "_mul_a"}, mul_a, 32'd0);
        check({name, "_mul_b"}, mul_b, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        rx_tdata  = 8'h00;
        rx_tvalid = 1'b0;
        tx_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // ADD 5 + 7, result one cycle after the last operand byte, RX blocked
        push_word(32'h0000000C);
        send_hdr(8'h01, 16'h000C);
        send_word(32'd5);
        send_word(32'd7);
        @(negedge clk);
        check("add_latency_tvalid", {31'd0, tx_tvalid}, 32'd1);
        check("add_result_rx_blocked", {31'd0, rx_tready}, 32'd0);
        wait_idle("add");

        // MUL 3 * 4 * 5
        push_mul(32'd3, 32'd4);
        push_mul(32'd12, 32'd5);
        push_word(32'h0000003C);
        send_hdr(8'h02, 16'h0010);
        send_word(32'd3);
        send_word(32'd4);
        send_word(32'd5);
        wait_idle("mul");

        // MUL overflow with TX backpressure on the result
        push_mul(32'h00010000, 32'h00010000);
        push_word(32'h00000000);
        send_hdr(8'h02, 16'h000C);
        send_word(32'h00010000);
        send_word(32'h00010000);
        tx_tready = 1'b0;
        repeat (12) @(posedge clk);
        #1 tx_tready = 1'b1;
        wait_idle("mul_ovf");

        // ECHO with a 10-cycle TX stall mid-payload
`ifdef ALU_SEQ_ECHO_EN
        push_word(32'hDEADBEEF);
`endif
        fork
            begin
                send_hdr(8'hEC, 16'h0008);
                send_word(32'hDEADBEEF);
            end
            begin
                repeat (6) @(posedge clk);
                #1 tx_tready = 1'b0;
                repeat (10) @(posedge clk);
                #1 tx_tready = 1'b1;
            end
        join
        wait_idle("echo");

        // Unknown opcode drained, then ADD 1 + 2
        push_word(32'h00000003);
        send_hdr(8'h7F, 16'h0008);
        send_word(32'h44332211);
        send_hdr(8'h01, 16'h000C);
        send_word(32'd1);
        send_word(32'd2);
        wait_idle("drain_add");

        // Empty payloads: ADD -> 0, MUL -> 1, len below header size -> 0
        push_word(32'h00000000);
        send_hdr(8'h01, 16'h0004);
        wait_idle("add_empty");
        push_word(32'h00000001);
        send_hdr(8'h02, 16'h0004);
        wait_idle("mul_empty");
        push_word(32'h00000000);
        send_hdr(8'h01, 16'h0002);
        wait_idle("add_short");

        // Trailing partial operand discarded
        push_word(32'h11223344);
        send_hdr(8'h01, 16'h000A);
        send_word(32'h11223344);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_idle("add_partial");

        // Reset mid-packet, then a clean ADD 9 + 1
        send_hdr(8'h01, 16'h000C);
        send_byte(8'h09);
        send_byte(8'h00);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        push_word(32'h0000000A);
        send_hdr(8'h01, 16'h000C);
        send_word(32'd9);
        send_word(32'd1);
        wait_idle("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
